seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It shares one BCD-to-7-segment decoder across NUM_DIGITS digits. Each cycle it drives the current digit's BCD code to the decoder and asserts a one-hot digit enable. It inserts a blanking interval between digits to prevent ghosting. New display values are double-buffered and committed only at frame boundaries, so a displayed number never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
TICK_DIV, 50000, clock cycles per digit slot (blank + show)
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off; must satisfy 1 <= BLANK_CYCLES < TICK_DIV

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  scan enable; low forces display dark
load  input  1  request to update the displayed value
digits_in  input  4*NUM_DIGITS  BCD digits; [3:0] is rightmost digit 0
load_ready  output  1  high when a load will be accepted
bcd_out  output  4  BCD code to the shared decoder (registered)
digit_en  output  NUM_DIGITS  one-hot active-high digit select (registered)
frame_done  output  1  one-cycle pulse at each frame wrap

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising clk edge.
- Reset values:
  - bcd_out = 0, digit_en = 0, frame_done = 0, load_ready = 1.
  - Display register = 0, pending register = 0, pending flag = 0.
  - Digit index = 0, slot counter = 0, state = BLANK.
- Reset mid-operation discards any pending load.
- State machine:
  - IDLE: entered whenever enable = 0. digit_en = 0, counter = 0, index = 0. When enable = 1, next state is BLANK.
  - BLANK: digit_en = 0; bcd_out = display digit[index]. After BLANK_CYCLES cycles, go to SHOW.
  - SHOW: digit_en = one-hot(index). At counter = TICK_DIV-1, go to BLANK with index+1. When index = NUM_DIGITS-1, index wraps to 0.
- Slot counter: width $clog2(TICK_DIV). It counts 0..TICK_DIV-1 across BLANK+SHOW and resets to 0 at each slot boundary.
- Timing: frame period = NUM_DIGITS*TICK_DIV cycles. The first slot after reset or enable rising starts one cycle later, after IDLE→BLANK.
- Load handshake:
  - load_ready = ~pending, combinational.
  - load && load_ready: digits_in is captured into the pending register and pending is set.
  - load while load_ready = 0 is ignored; the data is discarded.
- Commit: on the edge where index wraps NUM_DIGITS-1→0, if pending is set, pending is copied into the display register and pending clears. frame_done pulses high for that one cycle, whether or not a commit occurred.
- enable deassert: the next edge enters IDLE. Pending is held and commits at the next frame wrap after re-enable. No frame_done pulse is generated on abort.
- Invalid BCD (A–F) passes through unchanged on bcd_out; the decoder blanks it.
- Latency: digit_en and bcd_out are registered, so the change is visible one cycle after the state transition.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: in SHOW, digit_en stays 0 for any index above the highest nonzero display digit. Digit 0 is always shown. Slot timing, bcd_out and frame_done are unchanged.
- Undefined: all digits are shown, including leading zeros.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
1. Reset held 3 cycles, then enable=1 → outputs hold reset values during reset. After IDLE, 2 cycles of digit_en=0000 and bcd_out=0, then 6 cycles of digit_en=0001. Frame period is 32 cycles.
2. Mid-frame load with digits_in=16'h1234 → load_ready drops the next cycle and the display is unchanged until frame_done. On the next frame: digit_en 0001/0010/0100/1000 with bcd_out 4/3/2/1. load_ready returns to 1 after the commit.
3. load 16'h1234, then load 16'h5678 while load_ready=0 → the second load is ignored and the next frame shows 1234.
4. enable dropped during SHOW of digit 2 with a pending load → digit_en=0000 the next cycle, and no frame_done. On re-enable, the scan restarts at digit 0 and the pending value commits at the following wrap.
5. rst asserted mid-SHOW with pending=1 → all reset values next cycle; load_ready=1 and the display shows 0000.
6. Load 16'h00A0 → bcd_out=4'hA in the digit 1 slot. With SEG7_LEADING_ZERO_BLANK_EN defined, digit_en is 0000 during the digit 2 and 3 slots and 0001/0010 during the digit 0/1 slots.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a multi-digit
// common-cathode 7-segment display sharing one BCD decoder.
// Each digit slot is TICK_DIV cycles long: BLANK_CYCLES dark cycles,
// then the digit is lit for the remainder of the slot.
// New values are double-buffered and committed only at frame wrap.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN. When it is defined,
// leading zero digits stay dark; digit 0 is always shown.
//
//   state | meaning
//   idle  | scan disabled, display dark, counter/index held at 0
//   blank | start of a slot, all digits off (anti-ghosting)
//   show  | current digit enabled until the slot ends
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    load_ready,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [cnt_w-1:0] cnt_last   = cnt_w'(TICK_DIV - 1);
  localparam logic [cnt_w-1:0] blank_last = cnt_w'(BLANK_CYCLES - 1);
  localparam logic [idx_w-1:0] idx_last   = idx_w'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_blank = 2'd1,
    st_show  = 2'd2
  } state_t;

  state_t                  state;
  logic [cnt_w-1:0]        cnt;
  logic [idx_w-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic                    pend;

  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   show_mask;
  logic [NUM_DIGITS-1:0]   show_en;

  // A new value can only be accepted while the holding buffer is empty.
  assign load_ready = ~pend;

  // Select the current digit from the committed display value and decode the index.
  always_comb begin
    cur_digit = disp[{idx, 2'b00} +: 4];
    onehot    = '0;
    onehot[idx] = 1'b1;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is lit if it or any more-significant digit is nonzero; digit 0 always lit.
  always_comb begin
    logic keep;
    keep      = 1'b0;
    show_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      keep = keep | (disp[i*4 +: 4] != 4'd0) | (i == 0);
      show_mask[i] = keep;
    end
  end
`else
  // Every digit is lit, leading zeros included.
  always_comb begin
    show_mask = '1;
  end
`endif

  assign show_en = onehot & show_mask;

  // Scan FSM, slot timer, load buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= st_blank;
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      pend_data  <= '0;
      pend       <= 1'b0;
      bcd_out    <= 4'd0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Outputs follow the current state, so they lag a transition by one cycle;
      // dropping enable darkens the display on the very next edge.
      bcd_out    <= cur_digit;
      digit_en   <= (enable && state == st_show) ? show_en : '0;

      if (load && !pend) begin
        pend_data <= digits_in;
        pend      <= 1'b1;
      end

      if (!enable) begin
        // Abort: no frame_done and no commit; a pending value survives.
        state <= st_idle;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          st_idle: begin
            state <= st_blank;
            cnt   <= '0;
            idx   <= '0;
          end
          st_blank: begin
            cnt <= cnt + cnt_w'(1);
            if (cnt == blank_last) begin
              state <= st_show;
            end
          end
          st_show: begin
            if (cnt == cnt_last) begin
              cnt   <= '0;
              state <= st_blank;
              if (idx == idx_last) begin
                idx        <= '0;
                frame_done <= 1'b1;
                if (pend) begin
                  disp <= pend_data;
                  pend <= 1'b0;
                end
              end else begin
                idx <= idx + idx_w'(1);
              end
            end else begin
              cnt <= cnt + cnt_w'(1);
            end
          end
          default: begin
            state <= st_idle;
            cnt   <= '0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule
